// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizes rxd, samples each bit at mid-period and
// hands completed bytes to a one-entry holding register with a valid/ack handshake.
module uart_rx_core #(
  parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rd_en,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       ferr,
  output logic       overrun
);

  localparam logic [31:0] HALF_END = 32'(CLK_PER_HALF_BIT - 1);
  localparam logic [31:0] BIT_END  = 32'(2 * CLK_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q;
  logic        rxd_s_q;
  logic        rxd_s_d_q;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        ferr_q, ferr_d;
  logic        overrun_q, overrun_d;

  logic half_hit;
  logic bit_hit;
  logic byte_done;
  logic frame_err;

  assign half_hit = (cnt_q == HALF_END);
  assign bit_hit  = (cnt_q == BIT_END);

  // State and datapath registers; the synchronizer resets to the idle level
  // so a reset never manufactures a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sync1_q       <= 1'b1;
      rxd_s_q       <= 1'b1;
      rxd_s_d_q     <= 1'b1;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      // NOTE: data registers are reset too, so rdata reads 0 until the first byte.
      shift_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      ferr_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here so every flop samples pre-edge values.
      state_q       <= state_d;
      sync1_q       <= rxd;
      rxd_s_q       <= sync1_q;
      rxd_s_d_q     <= rxd_s_q;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      ferr_q        <= ferr_d;
      overrun_q     <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (rxd_s_d_q && !rxd_s_q) state_d = ST_START;
      ST_START: if (half_hit) state_d = rxd_s_q ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_hit && (bit_idx_q == 3'd7)) state_d = ST_STOP;
      // A good stop bit returns to IDLE at mid-stop, leaving half a bit to
      // catch the next start edge of a back-to-back frame.
      ST_STOP:  if (bit_hit) state_d = rxd_s_q ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rxd_s_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches.
    cnt_d     = cnt_q + 32'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      ST_IDLE: cnt_d = '0;
      ST_START: begin
        if (half_hit) begin
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_hit) begin
          cnt_d     = '0;
          shift_d   = {rxd_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (bit_hit) begin
          cnt_d     = '0;
          byte_done = rxd_s_q;
          frame_err = !rxd_s_q;
        end
      end
      ST_BREAK: cnt_d = '0;
      default:  cnt_d = '0;
    endcase

    rdata_d       = byte_done ? shift_q : rdata_q;
    rdata_valid_d = byte_done | (rdata_valid_q & ~rd_en);
    ferr_d        = frame_err;
    overrun_d     = byte_done & rdata_valid_q & ~rd_en;
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign ferr        = ferr_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: a timing-arithmetic receiver model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_rx_core;

  localparam int CPHB = 8;
  localparam int BIT  = 2 * CPHB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rd_en;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       ferr;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  int frame_start_edge = 0;
  int valid_rise_edge = 0;
  int valid_rise_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  bit prev_valid = 1'b0;
  bit model_ready = 1'b0;
  bit ok;
  bit ack_found;
  int base_ferr, base_ovr, base_rise;
  logic [9:0] frame_bits;

  uart_rx_core #(.CLK_PER_HALF_BIT(CPHB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rd_en      (rd_en),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .ferr       (ferr),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Receiver described by its sample schedule: after the synchronized falling
  // edge at cycle t0, bit j (0=start, 1..8=data, 9=stop) is read at t0+CPHB+j*BIT.
  typedef enum {M_IDLE, M_ACT, M_BRK} mmode_e;
  mmode_e     m_mode = M_IDLE;
  bit         m_s1 = 1, m_s = 1, m_sd = 1;
  int         m_t0 = 0;
  int         cyc = 0;
  logic [7:0] m_bits = '0;
  logic [7:0] exp_rdata = '0;
  logic       exp_valid = 0, exp_ferr = 0, exp_ovr = 0;

  task automatic model_step();
    bit done, fe;
    int off, j;
    if (rst) begin
      m_s1 = 1; m_s = 1; m_sd = 1;
      m_mode = M_IDLE; m_bits = '0;
      exp_rdata = '0; exp_valid = 0; exp_ferr = 0; exp_ovr = 0;
      model_ready = 1; cyc++;
      return;
    end
    done = 0; fe = 0;
    case (m_mode)
      M_IDLE: if (m_sd && !m_s) begin m_mode = M_ACT; m_t0 = cyc; end
      M_ACT: begin
        off = cyc - m_t0 - CPHB;
        if (off >= 0 && (off % BIT) == 0) begin
          j = off / BIT;
          if (j == 0) begin
            if (m_s) m_mode = M_IDLE;
          end else if (j <= 8) begin
            m_bits[j-1] = m_s;
          end else if (m_s) begin
            done = 1; m_mode = M_IDLE;
          end else begin
            fe = 1; m_mode = M_BRK;
          end
        end
      end
      M_BRK: if (m_s) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    exp_ferr = fe;
    exp_ovr  = done && exp_valid && !rd_en;
    if (done) begin
      exp_rdata = m_bits;
      exp_valid = 1;
    end else if (rd_en) begin
      exp_valid = 0;
    end
    m_sd = m_s; m_s = m_s1; m_s1 = rxd;
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare and event monitor ----------------
  initial forever begin
    @(negedge clk);
    if (model_ready) begin
      check("rdata", 32'(rdata), 32'(exp_rdata));
      check("rdata_valid", 32'(rdata_valid), 32'(exp_valid));
      check("ferr", 32'(ferr), 32'(exp_ferr));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      if (ferr === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      if (rdata_valid === 1'b1 && !prev_valid) begin
        valid_rise_edge = edge_cnt;
        valid_rise_cnt++;
      end
      prev_valid = (rdata_valid === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BIT) @(negedge clk);
  endtask

  // Called on a negedge; the start bit is captured at the next posedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    frame_start_edge = edge_cnt + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic wait_valid(input int max_cyc, output bit found);
    found = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rdata_valid === 1'b1) begin
        found = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; rxd = 1; rd_en = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic snap();
    base_ferr = ferr_cnt;
    base_ovr  = ovr_cnt;
    base_rise = valid_rise_cnt;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1; rxd = 1; rd_en = 0;
    do_reset();
    check("reset_rdata", 32'(rdata), 32'h0);
    check("reset_valid", 32'(rdata_valid), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);

    // 1: reset in the middle of data bit 3 of 0x29, line high afterwards
    do_reset();
    snap();
    frame_bits = {1'b1, 8'h29, 1'b0};
    for (int i = 0; i < 4; i++) drive_bit(frame_bits[i]);
    rxd = frame_bits[4];
    repeat (CPHB) @(negedge clk);
    rst = 1; rxd = 1;
    @(negedge clk);
    rst = 0;
    repeat (200) @(negedge clk);
    check("s1_no_valid", 32'(valid_rise_cnt - base_rise), 32'd0);
    check("s1_rdata", 32'(rdata), 32'h0);
    check("s1_ferr_cnt", 32'(ferr_cnt - base_ferr), 32'd0);

    // 2: single frame, latency from start edge to valid is 2+8+9*16 = 154 edges
    do_reset();
    snap();
    send_frame(8'h29, 1'b1);
    repeat (4) @(negedge clk);
    check("s2_latency", 32'(valid_rise_edge - frame_start_edge), 32'd154);
    check("s2_rdata", 32'(rdata), 32'h29);
    check("s2_ferr_cnt", 32'(ferr_cnt - base_ferr), 32'd0);
    check("s2_ovr_cnt", 32'(ovr_cnt - base_ovr), 32'd0);
    repeat (200) @(negedge clk);
    check("s2_valid_held", 32'(rdata_valid), 32'h1);

    // 3: back-to-back 0x55, 0xA3 with an ack after the first byte
    do_reset();
    snap();
    fork
      begin
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
      end
      begin
        wait_valid(400, ok);
        check("s3_first_valid_seen", 32'(ok), 32'h1);
        check("s3_first_byte", 32'(rdata), 32'h55);
        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
      end
    join
    repeat (4) @(negedge clk);
    check("s3_second_byte", 32'(rdata), 32'hA3);
    check("s3_valid", 32'(rdata_valid), 32'h1);
    check("s3_rises", 32'(valid_rise_cnt - base_rise), 32'd2);
    check("s3_ferr_cnt", 32'(ferr_cnt - base_ferr), 32'd0);
    check("s3_ovr_cnt", 32'(ovr_cnt - base_ovr), 32'd0);

    // 4: 4-clock start glitch, then a real 0x0F frame
    do_reset();
    snap();
    rxd = 0;
    repeat (4) @(negedge clk);
    rxd = 1;
    repeat (40) @(negedge clk);
    check("s4_glitch_no_valid", 32'(valid_rise_cnt - base_rise), 32'd0);
    check("s4_glitch_no_ferr", 32'(ferr_cnt - base_ferr), 32'd0);
    send_frame(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    check("s4_rdata", 32'(rdata), 32'h0F);
    check("s4_valid", 32'(rdata_valid), 32'h1);

    // 5: 0x81 with a low stop bit and a long low line, then 0x42
    do_reset();
    snap();
    send_frame(8'h81, 1'b0);
    repeat (60) @(negedge clk);
    rxd = 1;
    repeat (40) @(negedge clk);
    check("s5_one_ferr", 32'(ferr_cnt - base_ferr), 32'd1);
    check("s5_valid_low", 32'(rdata_valid), 32'h0);
    check("s5_no_rise", 32'(valid_rise_cnt - base_rise), 32'd0);
    send_frame(8'h42, 1'b1);
    repeat (4) @(negedge clk);
    check("s5_rdata", 32'(rdata), 32'h42);
    check("s5_valid", 32'(rdata_valid), 32'h1);
    check("s5_ferr_total", 32'(ferr_cnt - base_ferr), 32'd1);

    // 6: overrun on 0x22, then 0x33 acknowledged in its completion cycle
    do_reset();
    snap();
    send_frame(8'h11, 1'b1);
    repeat (20) @(negedge clk);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    check("s6_ovr_once", 32'(ovr_cnt - base_ovr), 32'd1);
    check("s6_rdata_22", 32'(rdata), 32'h22);
    check("s6_valid_22", 32'(rdata_valid), 32'h1);
    ack_found = 0;
    fork
      send_frame(8'h33, 1'b1);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (edge_cnt == frame_start_edge + 153) begin
            ack_found = 1;
            break;
          end
        end
        rd_en = 1;
        @(negedge clk);
        rd_en = 0;
      end
    join
    repeat (4) @(negedge clk);
    check("s6_ack_slot_found", 32'(ack_found), 32'h1);
    check("s6_no_new_ovr", 32'(ovr_cnt - base_ovr), 32'd1);
    check("s6_rdata_33", 32'(rdata), 32'h33);
    check("s6_valid_33", 32'(rdata_valid), 32'h1);
    check("s6_ferr_cnt", 32'(ferr_cnt - base_ferr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
